// File: rtl/spi_master_pkg.sv
// Shared SPI frame definitions for the threshold-write master and the slave-side top.
// Both ends derive the frame width from here so their layouts cannot drift apart.
package pulsar_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } spi_tx_state_t;

    function automatic int roundup8(input int n);
        return ((n + 7) / 8) * 8;
    endfunction

    // Frame = {id padded to whole bytes, value padded to whole bytes}.
    function automatic int frame_bits_f(input int pwm_width, input int num_pwm);
        return roundup8($clog2(pwm_width)) + roundup8(num_pwm);
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request handshake plus SPI pins of the threshold-write master.
interface spi_master_if #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 12
);
    localparam int ID_BITS = $clog2(pwm_width);

    logic                in_valid;
    logic                in_ready;
    logic [ID_BITS-1:0]  in_id;
    logic [num_pwm-1:0]  in_val;
    logic                busy;
    logic                done;
    logic                nCS;
    logic                SCK;
    logic                MOSI;

    modport master (
        output in_valid, in_id, in_val,
        input  in_ready, busy, done, nCS, SCK, MOSI
    );

    modport slave (
        input  in_valid, in_id, in_val,
        output in_ready, busy, done, nCS, SCK, MOSI
    );

endinterface

// File: rtl/spi_master.sv
// Serializes {threshold id, threshold value} writes into mode-0, MSB-first SPI frames.
// state | meaning
// IDLE  | nCS high, waiting for a request (in_ready high)
// SHIFT | clocking out frame bits, clk_div cycles per SCK half
// HOLD  | last bit sent, nCS still low for clk_div cycles
// GAP   | nCS high for clk_div cycles before the next frame
module spi_master
    import pulsar_spi_pkg::*;
#(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 12,
    parameter int clk_div   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_master_if.slave   bus
);

    localparam int ID_BITS    = $clog2(pwm_width);
    localparam int ID_W8      = roundup8(ID_BITS);
    localparam int VAL_W8     = roundup8(num_pwm);
    localparam int FRAME_BITS = frame_bits_f(pwm_width, num_pwm);
    localparam int HCNT_W     = $clog2(clk_div + 1);
    localparam int BCNT_W     = $clog2(FRAME_BITS + 1);

    localparam logic [HCNT_W-1:0] HALF_LAST = HCNT_W'(clk_div - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(FRAME_BITS - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

    spi_tx_state_t            state_q;
    logic [HCNT_W-1:0]        hcnt_q;
    logic [BCNT_W-1:0]        bcnt_q;
    logic [FRAME_BITS-2:0]    shreg_q;
    logic                     ncs_q;
    logic                     sck_q;
    logic                     mosi_q;
    logic                     busy_q;
    logic                     done_q;
    logic [FRAME_BITS-1:0]    frame_word;

    assign frame_word = {ID_W8'(bus.in_id), VAL_W8'(bus.in_val)};

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.nCS      = ncs_q;
    assign bus.SCK      = sck_q;
    assign bus.MOSI     = mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            ncs_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= SHIFT;
                        mosi_q  <= frame_word[FRAME_BITS-1];
                        shreg_q <= frame_word[FRAME_BITS-2:0];
                        ncs_q   <= 1'b0;
                        sck_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        hcnt_q  <= HALF_LAST;
                        bcnt_q  <= BIT_LAST;
                    end
                end
                SHIFT: begin
                    if (hcnt_q != '0) begin
                        hcnt_q <= hcnt_q - HCNT_ONE;
                    end else begin
                        hcnt_q <= HALF_LAST;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            // Falling edge: MOSI only moves here so the slave's rising-edge sample is clean.
                            sck_q <= 1'b0;
                            if (bcnt_q == '0) begin
                                state_q <= HOLD;
                                mosi_q  <= 1'b0;
                            end else begin
                                bcnt_q  <= bcnt_q - BCNT_ONE;
                                mosi_q  <= shreg_q[FRAME_BITS-2];
                                shreg_q <= shreg_q << 1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hcnt_q != '0) begin
                        hcnt_q <= hcnt_q - HCNT_ONE;
                    end else begin
                        state_q <= GAP;
                        ncs_q   <= 1'b1;
                        done_q  <= 1'b1;
                        hcnt_q  <= HALF_LAST;
                    end
                end
                GAP: begin
                    if (hcnt_q != '0) begin
                        hcnt_q <= hcnt_q - HCNT_ONE;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
# spi_master

Serializes threshold-write commands into SPI frames for the PWM controller's SPI slave input, so other logic (test harness, companion controller, self-test path) can program thresholds over the same wire interface. Accepts `{threshold id, threshold value}` through a valid/ready handshake and drives `nCS`/`SCK`/`MOSI`:
- SPI mode 0, MSB first.
- One frame per write, frame layout identical to what the slave decodes.

## Interface
Parameters:
- `pwm_width`, 16: number of threshold slots; id width is `$clog2(pwm_width)`.
- `num_pwm`, 12: threshold value width.
- `clk_div`, 2: SCK half-period in `clk` cycles, ≥1.

Derived:
- `id_bits = $clog2(pwm_width)`.
- `frame_bits = roundup8(id_bits) + roundup8(num_pwm)`; 24 at defaults.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `in_valid` in 1: write request present.
- `in_ready` out 1: block accepts request this cycle.
- `in_id` in id_bits: threshold slot.
- `in_val` in num_pwm: threshold value.
- `busy` out 1: frame in progress (from accept until return to IDLE).
- `done` out 1: one-cycle pulse when `nCS` deasserts at frame end.
- `nCS` out 1: chip select, active-low.
- `SCK` out 1: serial clock, idle low.
- `MOSI` out 1: serial data.

## Operation
- Frame word = `{zero-extended in_id to roundup8(id_bits), zero-extended in_val to roundup8(num_pwm)}`. Bit `frame_bits-1` is sent first.
- Handshake: transfer when `in_valid && in_ready`. `in_id`/`in_val` are captured into the shift register on that edge and may change afterwards. `in_ready = (state == IDLE)`; no queueing.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE -> SHIFT on transfer.
- SHIFT runs `frame_bits` bits. Each bit is `2*clk_div` cycles: `SCK` low for `clk_div` cycles, then high for `clk_div` cycles.
  - `MOSI` changes only while `SCK` low: at frame entry, and on each falling edge.
  - The slave samples on the rising edge.
- SHIFT -> HOLD after the last bit's high half; `SCK` returns low.
- HOLD: `clk_div` cycles, `nCS` low, `SCK` low.
- HOLD -> GAP: `nCS` rises; `done` pulses for exactly the first GAP cycle.
- GAP: `clk_div` cycles. GAP -> IDLE.
- Half-period counter is `$clog2(clk_div+1)` bits and counts `clk_div-1` down to 0. Bit counter is `$clog2(frame_bits+1)` bits.
- `rst_n` low, at any time including mid-frame:
  - Immediately forces IDLE, `nCS=1`, `SCK=0`, `MOSI=0`, `busy=0`, `done=0`, counters and shift register cleared.
  - The partial frame is abandoned; the slave discards it on `nCS` rise.
  - After release, `in_ready=1` in the first cycle.
- `in_valid` while not ready is ignored; there is no error flag.

## Timing
- All outputs except `in_ready` are registered. `in_ready` is decoded from the state register.
- Accept edge ends cycle 0. From cycle 1:
  - `nCS=0`, `SCK=0`, `MOSI` = frame MSB.
  - Rising `SCK` edges at cycles `1+clk_div+2*clk_div*k`, k = 0..frame_bits-1.
- `nCS` is low for `2*clk_div*frame_bits + clk_div` cycles: 98 at defaults.
- `done` is high in cycle `2*clk_div*frame_bits + clk_div + 1`.
- `in_ready` returns at cycle `2*clk_div*(frame_bits+1) + 1`: 101 at defaults.
- Back-to-back with `in_valid` held high: `nCS` high for exactly `clk_div+1` cycles between frames.
- Minimum `clk_div=1`: SCK = clk/2, every state visited for 1 cycle.

## Structure
- Shared package `pulsar_spi_pkg` holds:
  - `roundup8` function.
  - Frame-width derivation, so the same frame width serves this block and the slave-side top.
  - State enum `spi_tx_state_t` (IDLE, SHIFT, HOLD, GAP).
- No sub-module. The half-period counter, bit counter, shift register and FSM stay in one module of about 150 lines.

## Test plan
- Reset: hold `rst_n=0` -> `nCS=1`, `SCK=0`, `MOSI=0`, `busy=0`, `done=0`. Release -> `in_ready=1` in the first cycle.
- Single frame, defaults, `in_id=3`, `in_val=0xABC` -> exactly 24 SCK rising edges. Bits captured on rising edges = `0x030ABC`. `nCS` low 98 cycles. `done` pulses once. `in_ready` high again at cycle 101.
- Back-to-back with `in_valid` held, ids 1 and 2 -> two correct frames. `nCS` high exactly 3 cycles between them. Second request accepted in cycle 101.
- Reset mid-frame after the 10th rising edge -> `nCS`/`SCK` return to idle asynchronously. Next request (id=7, val=0x123) is serialized completely and correctly as `0x070123`.
- Loopback through slave, threshold memory and PWM at `clk_div=1`, id=5, val=0x0F0 -> slave `data_ready` pulses once with `0x0500F0`. Memory slot 5 reads `0x0F0`.
- Stability: change `in_id`/`in_val` every cycle during a frame -> transmitted word equals the value present at the accept edge.
